// File: rtl/pam_demod_pkg.sv
// Shared types and sizing helpers for the PAM hard-decision demodulator.
package pam_demod_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PILOT,
        DATA
    } state_t;

    function automatic int spw(input int width, input int bits);
        return width / bits;
    endfunction

    function automatic int num_levels(input int bits);
        return 1 << bits;
    endfunction

    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/pam_demod_axis_fifo.sv
// Word FIFO toward the AXI-Stream master; the head entry is held in a register
// so the stream outputs come straight from flops.
module axis_word_fifo #(
    parameter int DATA_W = 33,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] out_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              push_ok;
    logic              rest_empty;

    always_comb begin
        full       = (count_q == (PTR_W+1)'(DEPTH));
        empty      = (count_q == '0);
        push_ok    = push & (~full | pop);
        rest_empty = (count_q == (PTR_W+1)'(pop));
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
        data_d     = data_q;
        // The next head is the incoming word only when nothing older remains.
        if (count_d != '0) begin
            if (rest_empty) begin
                data_d = push_data;
            end else begin
                data_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
        end
    end

    assign out_data = data_q;

endmodule

// File: rtl/pam_demod_axis.sv
// PAM hard-decision demodulator: learns thresholds from a pilot ladder, slices
// payload samples into symbols and packs them MSB-first into AXI-Stream words.
module pam_demod_axis
    import pam_demod_pkg::*;
#(
    parameter int AD_WIDTH       = 12,
    parameter int PAM_BITS       = 2,
    parameter int LENGTH_DATA    = 1024,
    parameter int WIDTH_AXI_DATA = 32,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          syn_demod_valid,
    input  logic signed [AD_WIDTH-1:0]    syn_demod_data,
    input  logic                          m_axi_tready,
    output logic                          m_axi_tvalid,
    output logic [WIDTH_AXI_DATA-1:0]     m_axi_tdata,
    output logic [WIDTH_AXI_DATA/8-1:0]   m_axi_tkeep,
    output logic                          m_axi_tlast,
    input  logic                          ovf_clr,
    output logic                          overflow,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int L      = num_levels(PAM_BITS);
    localparam int NTHR   = L - 1;
    localparam int CNT_W  = cnt_width(LENGTH_DATA);
    localparam int SPW    = spw(WIDTH_AXI_DATA, PAM_BITS);
    localparam int SLOT_W = (SPW > 1) ? $clog2(SPW) : 1;

    state_t                      state_q, state_d;
    logic [PAM_BITS-1:0]         pilot_idx_q, pilot_idx_d;
    logic [CNT_W-1:0]            sym_cnt_q, sym_cnt_d;
    logic signed [AD_WIDTH-1:0]  prev_pilot_q, prev_pilot_d;
    logic signed [AD_WIDTH-1:0]  thr_q [NTHR];
    logic signed [AD_WIDTH-1:0]  thr_d [NTHR];
    logic [WIDTH_AXI_DATA-1:0]   acc_q, acc_d;
    logic [SLOT_W-1:0]           slot_q, slot_d;
    logic [WIDTH_AXI_DATA-1:0]   word_q, word_d;
    logic                        push_q, push_d;
    logic                        last_q, last_d;
    logic                        overflow_q, overflow_d;

    logic signed [AD_WIDTH:0]    pilot_sum;
    logic [PAM_BITS-1:0]         sym;
    logic [WIDTH_AXI_DATA-1:0]   new_acc;
    logic                        is_last;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_pop;
    logic [WIDTH_AXI_DATA:0]     fifo_out;

    // Slicer and packer operate on the live sample; results are registered below.
    always_comb begin
        pilot_sum = {prev_pilot_q[AD_WIDTH-1], prev_pilot_q}
                  + {syn_demod_data[AD_WIDTH-1], syn_demod_data};
        sym = '0;
        for (int k = 0; k < NTHR; k++) begin
            if (syn_demod_data > thr_q[k]) begin
                sym = sym + PAM_BITS'(1);
            end
        end
        new_acc = acc_q;
        for (int s = 0; s < SPW; s++) begin
            if (slot_q == SLOT_W'(s)) begin
                new_acc[WIDTH_AXI_DATA-1-PAM_BITS*s -: PAM_BITS] = sym;
            end
        end
        is_last = (sym_cnt_q == CNT_W'(LENGTH_DATA - 1));
    end

    always_comb begin
        state_d      = state_q;
        pilot_idx_d  = pilot_idx_q;
        sym_cnt_d    = sym_cnt_q;
        prev_pilot_d = prev_pilot_q;
        thr_d        = thr_q;
        acc_d        = acc_q;
        slot_d       = slot_q;
        word_d       = word_q;
        last_d       = 1'b0;
        push_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (syn_demod_valid) begin
                    prev_pilot_d = syn_demod_data;
                    pilot_idx_d  = PAM_BITS'(1);
                    state_d      = PILOT;
                end
            end
            PILOT: begin
                if (syn_demod_valid) begin
                    for (int k = 0; k < NTHR; k++) begin
                        if (pilot_idx_q == PAM_BITS'(k + 1)) begin
                            thr_d[k] = pilot_sum[AD_WIDTH:1];
                        end
                    end
                    prev_pilot_d = syn_demod_data;
                    if (pilot_idx_q == PAM_BITS'(L - 1)) begin
                        pilot_idx_d = '0;
                        sym_cnt_d   = '0;
                        state_d     = DATA;
                    end else begin
                        pilot_idx_d = pilot_idx_q + PAM_BITS'(1);
                    end
                end
            end
            DATA: begin
                if (syn_demod_valid) begin
                    if (slot_q == SLOT_W'(SPW - 1) || is_last) begin
                        word_d = new_acc;
                        push_d = 1'b1;
                        last_d = is_last;
                        acc_d  = '0;
                        slot_d = '0;
                    end else begin
                        acc_d  = new_acc;
                        slot_d = slot_q + SLOT_W'(1);
                    end
                    if (is_last) begin
                        sym_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        sym_cnt_d = sym_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A drop sets the sticky flag even when a clear is requested in the same cycle.
    always_comb begin
        fifo_pop   = m_axi_tvalid & m_axi_tready;
        overflow_d = overflow_q;
        if (push_q && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pilot_idx_q  <= '0;
            sym_cnt_q    <= '0;
            prev_pilot_q <= '0;
            for (int k = 0; k < NTHR; k++) begin
                thr_q[k] <= '0;
            end
            acc_q        <= '0;
            slot_q       <= '0;
            word_q       <= '0;
            push_q       <= 1'b0;
            last_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pilot_idx_q  <= pilot_idx_d;
            sym_cnt_q    <= sym_cnt_d;
            prev_pilot_q <= prev_pilot_d;
            thr_q        <= thr_d;
            acc_q        <= acc_d;
            slot_q       <= slot_d;
            word_q       <= word_d;
            push_q       <= push_d;
            last_q       <= last_d;
            overflow_q   <= overflow_d;
        end
    end

    axis_word_fifo #(
        .DATA_W(WIDTH_AXI_DATA + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_q),
        .push_data({last_q, word_q}),
        .pop      (fifo_pop),
        .out_data (fifo_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign m_axi_tvalid = ~fifo_empty;
    assign m_axi_tdata  = fifo_out[WIDTH_AXI_DATA-1:0];
    assign m_axi_tlast  = fifo_out[WIDTH_AXI_DATA];
    assign m_axi_tkeep  = '1;
    assign overflow     = overflow_q;
    assign busy         = (state_q != IDLE);
    assign frame_done   = push_q & last_q;

endmodule

// File: tb/tb_pam_demod_axis.sv
// Scoreboard bench for pam_demod_axis: a PAM-4 instance (20-symbol frames, 4-word
// FIFO) and a PAM-8 instance (10-symbol frames), checked against hand-computed words.
module tb_pam_demod_axis;

    typedef logic signed [11:0] samp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_valid, a_tready, a_tvalid, a_tlast, a_ovf_clr, a_overflow, a_busy, a_frame_done;
    samp_t       a_data;
    logic [31:0] a_tdata;
    logic [3:0]  a_tkeep;
    logic        b_valid, b_tready, b_tvalid, b_tlast, b_ovf_clr, b_overflow, b_busy, b_frame_done;
    samp_t       b_data;
    logic [31:0] b_tdata;
    logic [3:0]  b_tkeep;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          a_done_cnt = 0;
    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];

    samp_t pil1[4], pil2[4], pil_b[8];
    samp_t pay1[20], pay2[20], pay_b[10];

    pam_demod_axis #(.AD_WIDTH(12), .PAM_BITS(2), .LENGTH_DATA(20), .WIDTH_AXI_DATA(32), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .syn_demod_valid(a_valid), .syn_demod_data(a_data),
        .m_axi_tready(a_tready), .m_axi_tvalid(a_tvalid), .m_axi_tdata(a_tdata), .m_axi_tkeep(a_tkeep),
        .m_axi_tlast(a_tlast), .ovf_clr(a_ovf_clr), .overflow(a_overflow), .busy(a_busy),
        .frame_done(a_frame_done)
    );

    pam_demod_axis #(.AD_WIDTH(12), .PAM_BITS(3), .LENGTH_DATA(10), .WIDTH_AXI_DATA(32), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .syn_demod_valid(b_valid), .syn_demod_data(b_data),
        .m_axi_tready(b_tready), .m_axi_tvalid(b_tvalid), .m_axi_tdata(b_tdata), .m_axi_tkeep(b_tkeep),
        .m_axi_tlast(b_tlast), .ovf_clr(b_ovf_clr), .overflow(b_overflow), .busy(b_busy),
        .frame_done(b_frame_done)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic sel_b, input samp_t v);
        if (sel_b) begin
            b_valid = 1'b1;
            b_data  = v;
        end else begin
            a_valid = 1'b1;
            a_data  = v;
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendFrameA(input samp_t p[4], input samp_t d[20], input int gap, input int n_data);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, p[i]);
            if (gap > 0) idleCycles(gap);
        end
        checkOutput("busy_after_pilots", 64'(a_busy), 64'd1);
        for (int i = 0; i < n_data; i++) begin
            applyStimulus(1'b0, d[i]);
            if (gap > 0) idleCycles(gap);
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 300 && (exp_a.size() != 0 || exp_b.size() != 0); i++) @(posedge clk);
        #1;
        checkOutput("drain_a", 64'(exp_a.size()), 64'd0);
        checkOutput("drain_b", 64'(exp_b.size()), 64'd0);
    endtask

    task automatic expectFrame1();
        exp_a.push_back({1'b0, 32'h05B5_5555});
        exp_a.push_back({1'b1, 32'h5500_0000});
    endtask

    // Monitors: compare each transferred word against the head of its queue.
    always @(negedge clk) begin
        if (a_frame_done) a_done_cnt++;
        if (a_tvalid && a_tready) begin
            if (exp_a.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL a_unexpected_word: got 0x%0h last %0d, expected no word", a_tdata, a_tlast);
            end else begin
                checkOutput("a_word", 64'({a_tlast, a_tdata}), 64'(exp_a.pop_front()));
            end
        end
        if (b_tvalid && b_tready) begin
            if (exp_b.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL b_unexpected_word: got 0x%0h last %0d, expected no word", b_tdata, b_tlast);
            end else begin
                checkOutput("b_word", 64'({b_tlast, b_tdata}), 64'(exp_b.pop_front()));
            end
        end
    end

    initial begin
        pil1  = '{-12'sd300, -12'sd100, 12'sd100, 12'sd300};
        pil2  = '{-12'sd600, -12'sd200, 12'sd200, 12'sd600};
        pay1  = '{-12'sd250, -12'sd200, -12'sd199, 12'sd0, 12'sd1, 12'sd250,
                  12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0,
                  12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0};
        pay2  = '{-12'sd401, -12'sd400, -12'sd399, 12'sd0, 12'sd400, 12'sd401,
                  12'sd500, 12'sd500, 12'sd500, 12'sd500, 12'sd500, 12'sd500, 12'sd500,
                  12'sd500, 12'sd500, 12'sd500, 12'sd500, 12'sd500, 12'sd500, 12'sd500};
        pil_b = '{-12'sd700, -12'sd500, -12'sd300, -12'sd100, 12'sd100, 12'sd300, 12'sd500, 12'sd700};
        pay_b = '{12'sd100, -12'sd100, -12'sd700, 12'sd700, 12'sd600,
                  12'sd601, -12'sd600, -12'sd599, 12'sd0, 12'sd1};

        rst_n = 1'b0;
        a_valid = 1'b0; a_data = '0; a_tready = 1'b0; a_ovf_clr = 1'b0;
        b_valid = 1'b0; b_data = '0; b_tready = 1'b1; b_ovf_clr = 1'b0;
        idleCycles(3);
        checkOutput("rst_tvalid", 64'(a_tvalid), 64'd0);
        checkOutput("rst_tdata", 64'(a_tdata), 64'd0);
        checkOutput("rst_tlast", 64'(a_tlast), 64'd0);
        checkOutput("rst_overflow", 64'(a_overflow), 64'd0);
        checkOutput("rst_busy", 64'(a_busy), 64'd0);
        checkOutput("rst_frame_done", 64'(a_frame_done), 64'd0);
        checkOutput("rst_tkeep", 64'(a_tkeep), 64'hF);
        rst_n = 1'b1;
        idleCycles(2);

        $display("[TB] basic frame");
        a_tready = 1'b1;
        expectFrame1();
        sendFrameA(pil1, pay1, 0, 20);
        idleCycles(5);
        checkOutput("done_cnt_basic", 64'(a_done_cnt), 64'd1);
        checkOutput("busy_idle", 64'(a_busy), 64'd0);
        waitDrain();

        $display("[TB] gapped frame");
        expectFrame1();
        sendFrameA(pil1, pay1, 1, 20);
        idleCycles(5);
        checkOutput("done_cnt_gapped", 64'(a_done_cnt), 64'd2);
        waitDrain();

        $display("[TB] back-to-back frames");
        expectFrame1();
        exp_a.push_back({1'b0, 32'h05BF_FFFF});
        exp_a.push_back({1'b1, 32'hFF00_0000});
        sendFrameA(pil1, pay1, 0, 20);
        sendFrameA(pil2, pay2, 0, 20);
        idleCycles(5);
        checkOutput("done_cnt_b2b", 64'(a_done_cnt), 64'd4);
        waitDrain();

        $display("[TB] overflow with stalled sink");
        a_tready = 1'b0;
        expectFrame1();
        expectFrame1();
        for (int f = 0; f < 5; f++) sendFrameA(pil1, pay1, 0, 20);
        idleCycles(5);
        checkOutput("overflow_set", 64'(a_overflow), 64'd1);
        checkOutput("stall_tvalid", 64'(a_tvalid), 64'd1);
        checkOutput("stall_tdata", 64'(a_tdata), 64'h05B5_5555);
        checkOutput("done_cnt_ovf", 64'(a_done_cnt), 64'd9);
        a_ovf_clr = 1'b1;
        idleCycles(1);
        a_ovf_clr = 1'b0;
        checkOutput("overflow_clr", 64'(a_overflow), 64'd0);
        a_tready = 1'b1;
        waitDrain();

        $display("[TB] reset during payload");
        a_tready = 1'b0;
        sendFrameA(pil1, pay1, 0, 18);
        idleCycles(3);
        checkOutput("pre_rst_tvalid", 64'(a_tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_tvalid", 64'(a_tvalid), 64'd0);
        checkOutput("mid_rst_busy", 64'(a_busy), 64'd0);
        idleCycles(2);
        rst_n = 1'b1;
        a_tready = 1'b1;
        idleCycles(2);
        expectFrame1();
        sendFrameA(pil1, pay1, 0, 20);
        idleCycles(5);
        checkOutput("done_cnt_after_rst", 64'(a_done_cnt), 64'd10);
        waitDrain();

        $display("[TB] PAM-8 frame");
        exp_b.push_back({1'b1, 32'h8C7D_C170});
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, pil_b[i]);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, pay_b[i]);
        idleCycles(5);
        waitDrain();
        checkOutput("b_overflow", 64'(b_overflow), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
